// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, MDU op codes,
// MDU latency constants and small decode helpers.
package pipe_hazard_ctrl_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned EXC_W       = 4;
   localparam int unsigned CNT_W       = 6;
   localparam int unsigned MULT_CYCLES = 4;
   localparam int unsigned DIV_CYCLES  = 32;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MDU_BUSY  = 2'd1,
      ST_EXC_FLUSH = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MDU_NONE = 2'b00,
      MDU_MULT = 2'b01,
      MDU_DIV  = 2'b10,
      MDU_RSVD = 2'b11
   } mdu_op_e;

   function automatic logic is_mdu_issue(input logic [1:0] op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic [CNT_W-1:0] mdu_cycles(input logic [1:0] op);
      return (op == MDU_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/execute-side signal bundle between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if;
   import pipe_hazard_ctrl_pkg::*;

   logic [REG_W-1:0] id_rs;
   logic [REG_W-1:0] id_rt;
   logic             id_uses_rs;
   logic             id_uses_rt;
   logic [REG_W-1:0] ex_rt_dst;
   logic             ex_mem_read;
   logic [1:0]       id_mdu_op;
   logic             id_reads_hilo;
   logic [EXC_W-1:0] id_exc_code;

   logic             pc_write;
   logic             if_id_write;
   logic             id_ex_bubble;
   logic             if_id_flush;
   logic             mdu_start;
   logic             mdu_busy;
   logic [1:0]       state;

   modport master (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt_dst, ex_mem_read,
             id_mdu_op, id_reads_hilo, id_exc_code,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start,
             mdu_busy, state
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt_dst, ex_mem_read,
             id_mdu_op, id_reads_hilo, id_exc_code,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start,
             mdu_busy, state
   );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_cycle_counter.sv
// Multiply/divide latency counter: loads the op latency, then counts down to zero.
module mdu_cycle_counter
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             busy
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign busy = (cnt_q != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard controller: load-use and HI/LO stalls, MDU issue tracking,
// and the one-cycle exception flush sequence.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   pipe_hazard_ctrl_if.slave bus
);

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;

   logic             exc;
   logic             load_use;
   logic             mdu_issue;
   logic             hilo_hz;
   logic             busy_after_dec;

   logic             pc_write_c;
   logic             if_id_write_c;
   logic             id_ex_bubble_c;
   logic             if_id_flush_c;
   logic             mdu_start_c;

   mdu_cycle_counter u_cnt (
      .clock    (clock),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .cnt      (cnt),
      .busy     (busy)
   );

   assign exc       = (bus.id_exc_code != '0);
   assign load_use  = bus.ex_mem_read && (bus.ex_rt_dst != '0) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_rt_dst)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_rt_dst)));
   assign mdu_issue = is_mdu_issue(bus.id_mdu_op);
   assign hilo_hz   = busy && (bus.id_reads_hilo || mdu_issue);
   // Busy is still set after this edge only if the count has not just hit zero.
   assign busy_after_dec = (cnt > CNT_W'(1));

   always_comb begin
      pc_write_c     = 1'b1;
      if_id_write_c  = 1'b1;
      id_ex_bubble_c = 1'b0;
      if_id_flush_c  = 1'b0;
      mdu_start_c    = 1'b0;
      cnt_load       = 1'b0;
      cnt_load_val   = '0;
      state_d        = state_q;

      case (state_q)
         ST_RUN, ST_MDU_BUSY: begin
            state_d = busy_after_dec ? ST_MDU_BUSY : ST_RUN;
            if (exc) begin
               if_id_flush_c  = 1'b1;
               id_ex_bubble_c = 1'b0;
               pc_write_c     = 1'b1;
               state_d        = ST_EXC_FLUSH;
            end else if (load_use || hilo_hz) begin
               pc_write_c     = 1'b0;
               if_id_write_c  = 1'b0;
               id_ex_bubble_c = 1'b1;
            end else if (mdu_issue) begin
               mdu_start_c    = 1'b1;
               cnt_load       = 1'b1;
               cnt_load_val   = mdu_cycles(bus.id_mdu_op);
               state_d        = ST_MDU_BUSY;
            end
         end
         ST_EXC_FLUSH: begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_d        = busy_after_dec ? ST_MDU_BUSY : ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Held-in-reset pipeline: freeze fetch, flush IF/ID, bubble into EX.
      if (!reset) begin
         pc_write_c     = 1'b0;
         if_id_write_c  = 1'b0;
         id_ex_bubble_c = 1'b1;
         if_id_flush_c  = 1'b1;
         mdu_start_c    = 1'b0;
         cnt_load       = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign bus.pc_write     = pc_write_c;
   assign bus.if_id_write  = if_id_write_c;
   assign bus.id_ex_bubble = id_ex_bubble_c;
   assign bus.if_id_flush  = if_id_flush_c;
   assign bus.mdu_start    = mdu_start_c;
   assign bus.mdu_busy     = busy && reset;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences and
// randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   pipe_hazard_ctrl_if bus_if ();

   pipe_hazard_ctrl dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic [4:0] dst;
      logic       memrd;
      logic [1:0] op;
      logic       hilo;
      logic [3:0] exc;
      logic [4:0] exp_out;     // {pc_write, if_id_write, id_ex_bubble, if_id_flush, mdu_start}
      logic [1:0] exp_next_st;
      logic       exp_next_busy;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic [4:0] dst, input logic memrd,
                               input logic [1:0] op, input logic hilo,
                               input logic [3:0] exc, input logic [4:0] eo,
                               input logic [1:0] ens, input logic enb);
      vec_t v;
      v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.dst = dst;
      v.memrd = memrd; v.op = op; v.hilo = hilo; v.exc = exc;
      v.exp_out = eo; v.exp_next_st = ens; v.exp_next_busy = enb;
      return v;
   endfunction

   function automatic logic [4:0] outs();
      return {bus_if.pc_write, bus_if.if_id_write, bus_if.id_ex_bubble,
              bus_if.if_id_flush, bus_if.mdu_start};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      bus_if.id_rs = 5'd0;        bus_if.id_rt = 5'd0;
      bus_if.id_uses_rs = 1'b0;   bus_if.id_uses_rt = 1'b0;
      bus_if.ex_rt_dst = 5'd0;    bus_if.ex_mem_read = 1'b0;
      bus_if.id_mdu_op = 2'b00;   bus_if.id_reads_hilo = 1'b0;
      bus_if.id_exc_code = 4'h0;
   endtask

   task automatic drive(input vec_t v);
      bus_if.id_rs = v.rs;          bus_if.id_rt = v.rt;
      bus_if.id_uses_rs = v.urs;    bus_if.id_uses_rt = v.urt;
      bus_if.ex_rt_dst = v.dst;     bus_if.ex_mem_read = v.memrd;
      bus_if.id_mdu_op = v.op;      bus_if.id_reads_hilo = v.hilo;
      bus_if.id_exc_code = v.exc;
   endtask

   // Returns at a falling edge with reset just released.
   task automatic apply_reset();
      reset = 1'b0;
      set_idle();
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Reference model state: remaining MDU cycles and a pending flush cycle.
   int m_cnt;
   bit m_fl;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt_busy;
      set_idle();

      vecs[0]  = mk(5, 0, 1, 0, 5, 1, 2'b00, 0, 4'h0, 5'b00100, 2'd0, 1'b0); // load-use rs
      vecs[1]  = mk(0, 0, 1, 0, 0, 1, 2'b00, 0, 4'h0, 5'b11000, 2'd0, 1'b0); // dst r0
      vecs[2]  = mk(1, 7, 0, 1, 7, 1, 2'b00, 0, 4'h0, 5'b00100, 2'd0, 1'b0); // load-use rt
      vecs[3]  = mk(5, 0, 0, 0, 5, 1, 2'b00, 0, 4'h0, 5'b11000, 2'd0, 1'b0); // rs not read
      vecs[4]  = mk(5, 5, 1, 1, 5, 0, 2'b00, 0, 4'h0, 5'b11000, 2'd0, 1'b0); // not a load
      vecs[5]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 4'h0, 5'b11001, 2'd1, 1'b1); // mult issue
      vecs[6]  = mk(0, 0, 0, 0, 0, 0, 2'b10, 0, 4'h0, 5'b11001, 2'd1, 1'b1); // div issue
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 2'b11, 0, 4'h0, 5'b11000, 2'd0, 1'b0); // op 11 = none
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 4'h0, 5'b11000, 2'd0, 1'b0); // mfhi, idle MDU
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 4'h4, 5'b11010, 2'd2, 1'b0); // exception
      vecs[10] = mk(3, 0, 1, 0, 3, 1, 2'b10, 0, 4'h4, 5'b11010, 2'd2, 1'b0); // exc+lu+div
      vecs[11] = mk(3, 0, 1, 0, 3, 1, 2'b10, 0, 4'h0, 5'b00100, 2'd0, 1'b0); // lu beats div

      // Reset values while reset is held.
      #2;
      check("reset_outs", 32'(outs()), 32'(5'b00110));
      check("reset_state_busy", 32'({bus_if.state, bus_if.mdu_busy}), 32'(3'b000));

      for (int i = 0; i < 12; i++) begin
         apply_reset();
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_out));
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_next", i), 32'({bus_if.state, bus_if.mdu_busy}),
               32'({vecs[i].exp_next_st, vecs[i].exp_next_busy}));
      end

      // Load-use stall lasts one cycle once the bubble reaches EX.
      apply_reset();
      drive(vecs[0]);
      #1;
      check("lu_stall", 32'(outs()), 32'(5'b00100));
      @(negedge clock);
      bus_if.ex_mem_read = 1'b0;
      bus_if.ex_rt_dst = 5'd0;
      #1;
      check("lu_release", 32'(outs()), 32'(5'b11000));

      // Div issue, mfhi from T+5 stalls while busy.
      apply_reset();
      bus_if.id_mdu_op = 2'b10;
      #1;
      check("div_start", 32'(outs()), 32'(5'b11001));
      for (int k = 1; k <= 34; k++) begin
         @(negedge clock);
         bus_if.id_mdu_op = 2'b00;
         bus_if.id_reads_hilo = (k >= 5);
         #1;
         check($sformatf("div_k%0d", k),
               32'({bus_if.mdu_busy, bus_if.id_ex_bubble, bus_if.pc_write}),
               32'({(k <= 32), (k >= 5 && k <= 32), !(k >= 5 && k <= 32)}));
      end

      // Mult then independent ALU ops: no stalls, RUN after 4 cycles.
      apply_reset();
      bus_if.id_mdu_op = 2'b01;
      #1;
      check("mult_start", 32'(outs()), 32'(5'b11001));
      for (int k = 1; k <= 5; k++) begin
         @(negedge clock);
         set_idle();
         bus_if.id_uses_rs = 1'b1;
         bus_if.id_rs = 5'd3;
         #1;
         check($sformatf("mult_k%0d", k), 32'({bus_if.state, outs()}),
               32'({((k <= 4) ? 2'd1 : 2'd0), 5'b11000}));
      end

      // Exception during MDU_BUSY with cnt=10.
      apply_reset();
      bus_if.id_mdu_op = 2'b10;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clock);
         set_idle();
      end
      @(negedge clock);
      bus_if.id_exc_code = 4'h4;
      #1;
      check("exc_cycle", 32'({bus_if.state, outs()}), 32'({2'd1, 5'b11010}));
      @(negedge clock);
      #1;
      check("exc_flush", 32'({bus_if.state, outs()}), 32'({2'd2, 5'b11110}));
      @(negedge clock);
      bus_if.id_exc_code = 4'h0;
      #1;
      check("exc_return", 32'({bus_if.state, outs()}), 32'({2'd1, 5'b11000}));
      cnt_busy = 0;
      for (int j = 0; j < 40; j++) begin
         if (!bus_if.mdu_busy) break;
         cnt_busy++;
         @(negedge clock);
         #1;
      end
      check("exc_remaining_busy", 32'(cnt_busy), 32'd8);

      // Async reset in mid-div with cnt=20.
      apply_reset();
      bus_if.id_mdu_op = 2'b10;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         set_idle();
      end
      #2;
      check("pre_reset_busy", 32'({bus_if.state, bus_if.mdu_busy}), 32'(3'b011));
      reset = 1'b0;
      #1;
      check("async_reset", 32'({bus_if.state, bus_if.mdu_busy, outs()}), 32'({3'b000, 5'b00110}));
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("after_reset", 32'({bus_if.state, bus_if.mdu_busy, outs()}), 32'({3'b000, 5'b11000}));

      // Randomized traffic against the reference model.
      apply_reset();
      m_cnt = 0;
      m_fl  = 0;
      for (int it = 0; it < 3000; it++) begin
         logic       lu, mdu;
         logic [4:0] exp_o;
         logic       exp_b;
         logic [1:0] exp_s;
         int         nxt;
         reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         bus_if.id_rs = 5'($urandom_range(0, 3));
         bus_if.id_rt = 5'($urandom_range(0, 3));
         bus_if.id_uses_rs = 1'($urandom_range(0, 1));
         bus_if.id_uses_rt = 1'($urandom_range(0, 1));
         bus_if.ex_rt_dst = 5'($urandom_range(0, 3));
         bus_if.ex_mem_read = ($urandom_range(0, 3) == 0);
         bus_if.id_mdu_op = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         bus_if.id_reads_hilo = ($urandom_range(0, 3) == 0);
         bus_if.id_exc_code = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         #1;
         if (!reset) begin
            exp_o = 5'b00110; exp_b = 1'b0; exp_s = 2'd0;
            m_cnt = 0; m_fl = 0;
         end else begin
            lu  = bus_if.ex_mem_read && (bus_if.ex_rt_dst != 0) &&
                  ((bus_if.id_uses_rs && bus_if.id_rs == bus_if.ex_rt_dst) ||
                   (bus_if.id_uses_rt && bus_if.id_rt == bus_if.ex_rt_dst));
            mdu = (bus_if.id_mdu_op == 2'b01) || (bus_if.id_mdu_op == 2'b10);
            exp_b = (m_cnt > 0);
            exp_s = m_fl ? 2'd2 : ((m_cnt > 0) ? 2'd1 : 2'd0);
            nxt = (m_cnt > 0) ? m_cnt - 1 : 0;
            if (m_fl) begin
               exp_o = 5'b11110; m_fl = 0;
            end else if (bus_if.id_exc_code != 0) begin
               exp_o = 5'b11010; m_fl = 1;
            end else if (lu || (m_cnt > 0 && (bus_if.id_reads_hilo || mdu))) begin
               exp_o = 5'b00100;
            end else if (mdu) begin
               exp_o = 5'b11001;
               nxt = (bus_if.id_mdu_op == 2'b01) ? 4 : 32;
            end else begin
               exp_o = 5'b11000;
            end
            m_cnt = nxt;
         end
         check($sformatf("rand%0d", it), 32'({bus_if.state, bus_if.mdu_busy, outs()}),
               32'({exp_s, exp_b, exp_o}));
         @(negedge clock);
      end
      reset = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
